// File: rtl/rr_interval_meter_if.sv
// Beat-detector input bundle and R-R measurement output bundle.
// The master drives strobes; the slave reports intervals and asystole.
interface rr_interval_meter_if #(
    parameter int CNT_WIDTH = 12
);
    logic                 i_ce;
    logic                 i_beat;
    logic [CNT_WIDTH-1:0] o_rr;
    logic                 o_rr_valid;
    logic [CNT_WIDTH-1:0] o_rr_avg;
    logic                 o_avg_valid;
    logic                 o_asystole;

    modport master (
        output i_ce, i_beat,
        input  o_rr, o_rr_valid, o_rr_avg, o_avg_valid, o_asystole
    );

    modport slave (
        input  i_ce, i_beat,
        output o_rr, o_rr_valid, o_rr_avg, o_avg_valid, o_asystole
    );
endinterface

// File: rtl/rr_interval_meter.sv
// R-R interval meter: tick count between beats, running mean over the
// last 2^AVG_LOG2 intervals, and asystole flag after MAX_RR silent ticks.
module rr_interval_meter #(
    parameter int CNT_WIDTH = 12,
    parameter int MAX_RR    = 1080,
    parameter int AVG_LOG2  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    rr_interval_meter_if.slave bus
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = CNT_WIDTH + AVG_LOG2;
    localparam logic [CNT_WIDTH-1:0] MAX_C  = CNT_WIDTH'(MAX_RR);
    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
    localparam logic [AVG_LOG2:0]    FULL   = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [AVG_LOG2:0]    F_ONE  = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2-1:0]  P_ONE  = AVG_LOG2'(1);

    typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  rr_q, rr_d;
    logic                  rr_valid_q, rr_valid_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [AVG_LOG2:0]     fill_q, fill_d;
    logic [AVG_LOG2-1:0]   wptr_q, wptr_d;
    logic [CNT_WIDTH-1:0]  buf_q [DEPTH];

    logic                  cap;
    logic                  full;
    logic [CNT_WIDTH-1:0]  interval;
    logic [CNT_WIDTH-1:0]  oldest;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        rr_valid_d = 1'b0;
        sum_d      = sum_q;
        fill_d     = fill_q;
        wptr_d     = wptr_q;
        cap        = 1'b0;
        full       = (fill_q == FULL);
        oldest     = buf_q[wptr_q];
        // A tick coinciding with the beat belongs to the ending interval.
        interval   = cnt_q + (bus.i_ce ? ONE : '0);

        unique case (state_q)
            IDLE: begin
                if (bus.i_beat) begin
                    cnt_d   = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (bus.i_beat) begin
                    cap   = 1'b1;
                    cnt_d = '0;
                end else if (bus.i_ce) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q + ONE == MAX_C) begin
                        state_d = TIMEOUT;
                    end
                end
            end
            TIMEOUT: begin
                if (bus.i_beat) begin
                    cnt_d   = '0;
                    state_d = MEASURE;
                    sum_d   = '0;
                    fill_d  = '0;
                    wptr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap) begin
            rr_d       = interval;
            rr_valid_d = 1'b1;
            sum_d      = sum_q + SW'(interval) - (full ? SW'(oldest) : '0);
            wptr_d     = wptr_q + P_ONE;
            if (!full) begin
                fill_d = fill_q + F_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_q       <= '0;
            rr_valid_q <= 1'b0;
            sum_q      <= '0;
            fill_q     <= '0;
            wptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            rr_valid_q <= rr_valid_d;
            sum_q      <= sum_d;
            fill_q     <= fill_d;
            wptr_q     <= wptr_d;
        end
    end

    // Stale entries are harmless: fill gates when the oldest is subtracted.
    always_ff @(posedge i_clk) begin
        if (cap) begin
            buf_q[wptr_q] <= interval;
        end
    end

    assign bus.o_rr        = rr_q;
    assign bus.o_rr_valid  = rr_valid_q;
    assign bus.o_rr_avg    = sum_q[SW-1:AVG_LOG2];
    assign bus.o_avg_valid = (fill_q == FULL);
    assign bus.o_asystole  = (state_q == TIMEOUT);
endmodule

// File: tb/tb_rr_interval_meter.sv
// Randomized and directed bench for rr_interval_meter with a queue
// scoreboard fed by an interval-history reference model.
module tb_rr_interval_meter;
    localparam int CW    = 12;
    localparam int MAXRR = 1080;
    localparam int DEP   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_interval_meter_if #(.CNT_WIDTH(CW)) bus ();

    rr_interval_meter #(
        .CNT_WIDTH(CW),
        .MAX_RR   (MAXRR),
        .AVG_LOG2 (3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        int due;
        int rr;
        int avg;
        bit full;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   started = 0;
    bit   exp_asys = 0;
    bit   exp_full = 0;

    // Reference model: beat history and tick count since last beat.
    bit   have_ref;
    bit   timed_out;
    int   ticks;
    int   hist[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hist_sum();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    task automatic step(input bit c, input bit b);
        exp_t e;
        bus.i_ce   = c;
        bus.i_beat = b;
        if (b) begin
            if (!have_ref) begin
                have_ref = 1;
                ticks = 0;
            end else if (timed_out) begin
                timed_out = 0;
                ticks = 0;
                hist.delete();
            end else begin
                hist.push_back(ticks + (c ? 1 : 0));
                if (hist.size() > DEP) void'(hist.pop_front());
                e.due  = cyc + 1;
                e.rr   = ticks + (c ? 1 : 0);
                e.avg  = hist_sum() / DEP;
                e.full = (hist.size() == DEP);
                q.push_back(e);
                ticks = 0;
            end
        end else if (c && have_ref && !timed_out) begin
            ticks++;
            if (ticks == MAXRR) timed_out = 1;
        end
        @(posedge clk);
        exp_asys = timed_out;
        exp_full = (hist.size() == DEP);
        #1;
    endtask

    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) step((i % period) == period - 1, 1'b0);
    endtask

    task automatic beat(input bit c);
        step(c, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_ce = 1'b0;
        bus.i_beat = 1'b0;
        have_ref = 0;
        timed_out = 0;
        ticks = 0;
        hist.delete();
        @(posedge clk);
        exp_asys = 0;
        exp_full = 0;
        #1;
        checks++;
        if (bus.o_rr !== '0 || bus.o_rr_valid !== 1'b0 ||
            bus.o_rr_avg !== '0 || bus.o_avg_valid !== 1'b0 ||
            bus.o_asystole !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rr=%0d v=%b avg=%0d av=%b asy=%b need all 0",
                     bus.o_rr, bus.o_rr_valid, bus.o_rr_avg,
                     bus.o_avg_valid, bus.o_asystole);
        end
        rst = 1'b0;
        started = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            checks++;
            if (bus.o_asystole !== exp_asys) begin
                errors++;
                $display("FAIL asystole cyc=%0d got %b need %b",
                         cyc, bus.o_asystole, exp_asys);
            end
            checks++;
            if (bus.o_avg_valid !== exp_full) begin
                errors++;
                $display("FAIL avg_valid cyc=%0d got %b need %b",
                         cyc, bus.o_avg_valid, exp_full);
            end
            if (bus.o_rr_valid === 1'b1) begin
                checks++;
                if (q.size() == 0 || q[0].due != cyc) begin
                    errors++;
                    $display("FAIL spurious_rr cyc=%0d got rr=%0d need no pulse",
                             cyc, bus.o_rr);
                end else begin
                    e = q.pop_front();
                    if (bus.o_rr !== CW'(e.rr)) begin
                        errors++;
                        $display("FAIL rr cyc=%0d got %0d need %0d",
                                 cyc, bus.o_rr, e.rr);
                    end
                    if (e.full) begin
                        checks++;
                        if (bus.o_rr_avg !== CW'(e.avg)) begin
                            errors++;
                            $display("FAIL rr_avg cyc=%0d got %0d need %0d",
                                     cyc, bus.o_rr_avg, e.avg);
                        end
                    end
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rr cyc=%0d got no pulse need rr=%0d",
                         cyc, q[0].rr);
                void'(q.pop_front());
            end
        end
    end

    bit c, b, pb;
    int mode;

    initial begin
        bus.i_ce = 1'b0;
        bus.i_beat = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run(9, 1); beat(1); run(299, 1); beat(1);
        run(20, 1);

        beat(1);
        repeat (8) begin run(1199, 4); beat(1); end
        repeat (4) begin
            run(1119, 4); beat(1);
            run(1279, 4); beat(1);
        end

        beat(1); run(1100, 1); beat(1); run(249, 1); beat(1);

        beat(1); run(1079, 1); beat(1);

        beat(1); run(299, 1); beat(1); run(299, 1); beat(0);

        repeat (9) begin run(99, 1); beat(1); end
        run(150, 1);
        do_reset();
        beat(1); run(199, 1); beat(1);

        beat(1); run(2000, 3000); beat(1);

        pb = 0;
        repeat (6) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 1500; i++) begin
                c = (mode == 0) ? 1'b1 : ($urandom_range(0, mode) == 0);
                b = ($urandom_range(0, (mode == 2) ? 3000 : 250) == 0) ||
                    (pb && $urandom_range(0, 2) == 0);
                step(c, b);
                pb = b;
            end
        end

        run(4, 1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending need 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
